// File: rtl/if_stage.sv
// if_stage -- instruction-fetch stage of the five-stage RISC-V core.
//
// Holds the program counter, presents it combinationally to the instruction
// ROM, and captures the returned word into the IF/ID pipeline register.
// A one-cycle BOOT bubble follows reset. Stalls from ID freeze the stage.
// Redirects from EX reload the PC and flush IF/ID. A misaligned redirect
// target halts fetch permanently until reset.
//
// Ports:
//   CLK             clock, rising edge
//   RST             synchronous active-high reset
//   stall_if        hold PC and IF/ID (load-use stall from ID)
//   redirect_valid  taken branch/jump resolved in EX
//   redirect_target new PC when redirect_valid=1
//   rom_addr        fetch address to the instruction ROM (equals pc)
//   rom_inst        instruction word returned by the ROM, same cycle
//   id_pc           PC of the instruction held in IF/ID
//   id_inst         instruction held in IF/ID
//   id_valid        IF/ID holds a real instruction
//   fetch_fault     sticky: misaligned redirect seen, fetch halted
//   fetch_cnt       number of instructions captured into IF/ID
module if_stage #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [31:0]       NOP_INST = 32'h0000_0013
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              stall_if,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_inst,
  output logic [ADDR_W-1:0] id_pc,
  output logic [31:0]       id_inst,
  output logic              id_valid,
  output logic              fetch_fault,
  output logic [31:0]       fetch_cnt
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] id_pc_q;
  logic [31:0]       id_inst_q;
  logic              id_valid_q;
  logic              fault_q;
  logic [31:0]       cnt_q;

  logic redir_ok;
  logic redir_bad;
  logic capture;

  // Sequential PC; the addition wraps modulo 2^ADDR_W by construction.
  function automatic logic [ADDR_W-1:0] pc_incr(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(4);
  endfunction

  // Fetch counter wraps 0xFFFF_FFFF -> 0.
  function automatic logic [31:0] cnt_incr(input logic [31:0] cnt);
    return cnt + 32'd1;
  endfunction

  assign rom_addr    = pc_q;
  assign id_pc       = id_pc_q;
  assign id_inst     = id_inst_q;
  assign id_valid    = id_valid_q;
  assign fetch_fault = fault_q;
  assign fetch_cnt   = cnt_q;

  // State register
  always_ff @(posedge CLK) begin
    if (RST) state_q <= BOOT;
    else     state_q <= state_d;
  end

  // Next state and per-cycle action decode. A redirect outranks the stall,
  // and is honoured in BOOT exactly as in RUN.
  always_comb begin
    state_d   = state_q;
    redir_ok  = 1'b0;
    redir_bad = 1'b0;
    capture   = 1'b0;
    case (state_q)
      BOOT, RUN: begin
        if (redirect_valid) begin
          if (redirect_target[1:0] != 2'b00) begin
            redir_bad = 1'b1;
            state_d   = HALT;
          end else begin
            redir_ok = 1'b1;
            state_d  = RUN;
          end
        end else if (state_q == BOOT) begin
          state_d = RUN;
        end else if (!stall_if) begin
          capture = 1'b1;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = BOOT;
    endcase
  end

  // PC / IF-ID register boundary
  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_q       <= RESET_PC;
      id_pc_q    <= '0;
      id_inst_q  <= NOP_INST;
      id_valid_q <= 1'b0;
      fault_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      if (redir_ok || redir_bad) begin
        // Flush: the instruction in IF/ID is on the wrong path.
        pc_q       <= redirect_target;
        id_pc_q    <= '0;
        id_inst_q  <= NOP_INST;
        id_valid_q <= 1'b0;
      end else if (capture) begin
        pc_q       <= pc_incr(pc_q);
        id_pc_q    <= pc_q;
        id_inst_q  <= rom_inst;
        id_valid_q <= 1'b1;
        cnt_q      <= cnt_incr(cnt_q);
      end
      if (redir_bad) fault_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        CLK;
  logic        RST;
  logic        stall_if;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;
  logic        fetch_fault;
  logic [31:0] fetch_cnt;

  int checks   = 0;
  int failures = 0;

  if_stage #(
    .ADDR_W  (32),
    .RESET_PC(32'h0000_0000),
    .NOP_INST(NOP)
  ) dut (
    .CLK            (CLK),
    .RST            (RST),
    .stall_if       (stall_if),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .rom_addr       (rom_addr),
    .rom_inst       (rom_inst),
    .id_pc          (id_pc),
    .id_inst        (id_inst),
    .id_valid       (id_valid),
    .fetch_fault    (fetch_fault),
    .fetch_cnt      (fetch_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Instruction ROM contents: the program from the test plan in words 0..3,
  // a scrambled pattern everywhere else so every address is distinguishable.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    logic [31:0] prog [4];
    prog[0] = 32'h0050_0093;
    prog[1] = 32'h0060_0113;
    prog[2] = 32'h0020_81B3;
    prog[3] = 32'h0000_0013;
    if (a < 32'd16) return prog[a[3:2]];
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  always_comb rom_inst = rom_word(rom_addr);

  // Reference model: architectural view of the fetch stage.
  logic [31:0] m_pc, m_id_pc, m_id_inst, m_cnt;
  logic        m_id_valid, m_fault, m_booting, m_halted;

  task automatic model_edge(input logic rst, input logic stall, input logic rv,
                            input logic [31:0] tgt);
    logic [31:0] fetched;
    fetched = rom_word(m_pc);
    if (rst) begin
      m_pc = 0; m_id_pc = 0; m_id_inst = NOP; m_id_valid = 0;
      m_fault = 0; m_cnt = 0; m_booting = 1; m_halted = 0;
    end else if (m_halted) begin
      // frozen until reset
    end else if (rv) begin
      m_pc = tgt; m_id_pc = 0; m_id_inst = NOP; m_id_valid = 0;
      m_booting = 0;
      if (tgt % 4 != 0) begin
        m_fault = 1; m_halted = 1;
      end
    end else if (m_booting) begin
      m_booting = 0;
    end else if (!stall) begin
      m_id_pc = m_pc; m_id_inst = fetched; m_id_valid = 1;
      m_pc = m_pc + 4; m_cnt = m_cnt + 1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string where);
    chk({where, ":rom_addr"},    rom_addr,            m_pc);
    chk({where, ":id_pc"},       id_pc,               m_id_pc);
    chk({where, ":id_inst"},     id_inst,             m_id_inst);
    chk({where, ":id_valid"},    {31'd0, id_valid},   {31'd0, m_id_valid});
    chk({where, ":fetch_fault"}, {31'd0, fetch_fault}, {31'd0, m_fault});
    chk({where, ":fetch_cnt"},   fetch_cnt,           m_cnt);
  endtask

  // One clock: drive inputs, take the edge, advance the model, check #1 later.
  task automatic step(input string where, input logic rst, input logic stall,
                      input logic rv, input logic [31:0] tgt);
    RST = rst; stall_if = stall; redirect_valid = rv; redirect_target = tgt;
    @(posedge CLK);
    model_edge(rst, stall, rv, tgt);
    #1;
    check_all(where);
  endtask

  initial begin
    logic [31:0] held_pc, held_inst, held_cnt;
    RST = 1'b1; stall_if = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
    m_pc = 0; m_id_pc = 0; m_id_inst = NOP; m_id_valid = 0;
    m_fault = 0; m_cnt = 0; m_booting = 1; m_halted = 0;
    #2;

    // Reset release and first fetches
    step("reset", 1, 0, 0, 0);
    chk("reset_inst", id_inst, NOP);
    step("boot", 0, 0, 0, 0);
    chk("boot_valid", {31'd0, id_valid}, 32'd0);
    step("edge2", 0, 0, 0, 0);
    chk("edge2_inst", id_inst, 32'h0050_0093);
    chk("edge2_pc", id_pc, 32'h0);
    step("edge3", 0, 0, 0, 0);
    chk("edge3_pc", id_pc, 32'h4);
    chk("edge3_cnt", fetch_cnt, 32'd2);

    // Three-cycle stall
    held_pc = rom_addr; held_inst = id_inst; held_cnt = fetch_cnt;
    for (int i = 0; i < 3; i++) begin
      step("stall", 0, 1, 0, 0);
      chk("stall_pc", rom_addr, held_pc);
      chk("stall_inst", id_inst, held_inst);
      chk("stall_cnt", fetch_cnt, held_cnt);
    end
    step("post_stall", 0, 0, 0, 0);
    chk("post_stall_idpc", id_pc, 32'h8);

    // Redirect to 0x40
    step("redir", 0, 0, 1, 32'h40);
    chk("redir_addr", rom_addr, 32'h40);
    chk("redir_inst", id_inst, NOP);
    step("redir_next", 0, 0, 0, 0);
    chk("redir_next_pc", id_pc, 32'h40);

    // Redirect and stall together
    held_cnt = fetch_cnt;
    step("redir_stall", 0, 1, 1, 32'h20);
    chk("redir_stall_addr", rom_addr, 32'h20);
    chk("redir_stall_cnt", fetch_cnt, held_cnt);
    step("run", 0, 0, 0, 0);

    // Misaligned redirect halts
    step("misalign", 0, 0, 1, 32'h22);
    chk("misalign_fault", {31'd0, fetch_fault}, 32'd1);
    step("halt_redir", 0, 0, 1, 32'h100);
    step("halt_stall", 0, 1, 0, 0);
    step("halt_idle", 0, 0, 0, 0);
    chk("halt_valid", {31'd0, id_valid}, 32'd0);
    step("halt_reset", 1, 0, 0, 0);
    chk("halt_reset_fault", {31'd0, fetch_fault}, 32'd0);
    chk("halt_reset_cnt", fetch_cnt, 32'd0);

    // PC wrap at the top of the address space
    step("boot2", 0, 0, 0, 0);
    step("wrap_redir", 0, 0, 1, 32'hFFFF_FFFC);
    step("wrap_fetch", 0, 0, 0, 0);
    chk("wrap_pc", rom_addr, 32'h0);
    chk("wrap_idpc", id_pc, 32'hFFFF_FFFC);
    step("wrap_next", 0, 0, 0, 0);

    // Redirect during BOOT
    step("boot_rst", 1, 0, 0, 0);
    step("boot_redir", 0, 0, 1, 32'h8);
    step("boot_redir_next", 0, 0, 0, 0);
    chk("boot_redir_pc", id_pc, 32'h8);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic r, s, rv;
      logic [31:0] t;
      r  = ($urandom_range(0, 49) == 0);
      s  = ($urandom_range(0, 3) == 0);
      rv = ($urandom_range(0, 9) == 0);
      t  = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
      if ($urandom_range(0, 19) == 0) t[1:0] = 2'($urandom_range(1, 3));
      step("rand", r, s, rv, t);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
